// File: rtl/config_pkg.sv
// Global configuration shared across the core.
//   XLEN : machine word width; also the width of a page-table entry.
package config_pkg;
   localparam int XLEN = 64;
endpackage

// File: rtl/mmu_pkg.sv
// Types shared by the MMU blocks.
//   fill_state_e : states of the TLB fill controller.
package mmu_pkg;
   typedef enum logic {
      FILL_IDLE  = 1'b0,
      FILL_WRITE = 1'b1
   } fill_state_e;
endpackage

// File: rtl/tlbplru.sv
// Tree pseudo-LRU replacement state for a TLB.
//   clk, reset    : clock, synchronous active-high reset (all node bits -> 0)
//   access_valid  : an entry was used this cycle
//   access_idx    : index of the used entry
//   victim        : least-recently-used entry according to the tree
// Node n has children 2n+1 (lower half) and 2n+2 (upper half). A node bit of
// 0 sends the victim search to the lower half, 1 to the upper half.
module tlbplru #(
   parameter int ENTRIES = 8,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             access_valid,
   input  logic [IDX_W-1:0] access_idx,
   output logic [IDX_W-1:0] victim
);

   logic [ENTRIES-2:0] tree_q;
   logic [ENTRIES-2:0] tree_d;

   // Victim walk: follow node bits from the root down to a leaf.
   always_comb begin
      int node;
      node   = 0;
      victim = '0;
      for (int lvl = 0; lvl < IDX_W; lvl++) begin
         victim[IDX_W-1-lvl] = tree_q[node];
         node = 2 * node + 1 + int'(tree_q[node]);
      end
   end

   // Access update: every node on the path is pointed away from the access.
   always_comb begin
      int  node;
      logic b;
      tree_d = tree_q;
      node   = 0;
      b      = 1'b0;
      if (access_valid) begin
         for (int lvl = 0; lvl < IDX_W; lvl++) begin
            b            = access_idx[IDX_W-1-lvl];
            tree_d[node] = ~b;
            node         = 2 * node + 1 + int'(b);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) tree_q <= '0;
      else       tree_q <= tree_d;
   end

endmodule

// File: rtl/tlb_fill_ctrl.sv
// TLB fill controller: accepts leaf PTEs from the page walker, picks a victim
// line (first invalid line, else tree-PLRU), writes it one cycle later, and
// maintains per-line valid bits including sfence.vma flushes.
//   clk, reset  : clock, synchronous active-high reset
//   FillValid/FillReady/FillPTE : fill handshake from the page walker
//   TLBAccess, HitVec           : lookup hits, used to refresh the PLRU
//   GlobalVec                   : PTE_G bit of each line
//   SFenceValid, SFenceAll      : flush request; all lines or non-global only
//   WriteEn, WritePTE           : one-hot line write strobe and its data
//   Valid                       : per-line valid bits
//   Busy                        : a write is in progress
module tlb_fill_ctrl
   import config_pkg::*;
   import mmu_pkg::*;
#(
   parameter int TLB_ENTRIES = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   FillValid,
   output logic                   FillReady,
   input  logic [XLEN-1:0]        FillPTE,
   input  logic                   TLBAccess,
   input  logic [TLB_ENTRIES-1:0] HitVec,
   input  logic [TLB_ENTRIES-1:0] GlobalVec,
   input  logic                   SFenceValid,
   input  logic                   SFenceAll,
   output logic [TLB_ENTRIES-1:0] WriteEn,
   output logic [XLEN-1:0]        WritePTE,
   output logic [TLB_ENTRIES-1:0] Valid,
   output logic                   Busy
);

   localparam int IDX_W = $clog2(TLB_ENTRIES);

   fill_state_e            state_q, state_d;
   logic                   accept;
   logic [XLEN-1:0]        pte_p1;
   logic [IDX_W-1:0]       victim_p1;
   logic [TLB_ENTRIES-1:0] valid_q;
   logic [IDX_W-1:0]       plru_victim;
   logic [IDX_W-1:0]       free_idx;
   logic                   free_found;
   logic [IDX_W-1:0]       hit_idx;
   logic                   write_commit;
   logic                   plru_acc;
   logic [IDX_W-1:0]       plru_idx;
   logic [IDX_W-1:0]       next_victim;

   // Lowest-index invalid line; descending scan so the lowest hit wins.
   always_comb begin
      free_idx   = '0;
      free_found = 1'b0;
      for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_idx   = IDX_W'(i);
            free_found = 1'b1;
         end
      end
   end

   // One-hot to binary; HitVec is one-hot so OR-ing indices is exact.
   always_comb begin
      hit_idx = '0;
      for (int i = 0; i < TLB_ENTRIES; i++) begin
         if (HitVec[i]) hit_idx = hit_idx | IDX_W'(i);
      end
   end

   assign next_victim = free_found ? free_idx : plru_victim;

   // A fill write that actually lands owns the PLRU port; hits are only
   // applied from IDLE, so a hit during WRITE is dropped.
   assign write_commit = (state_q == FILL_WRITE) && !SFenceValid;
   assign plru_acc     = write_commit ||
                         ((state_q == FILL_IDLE) && TLBAccess && (|HitVec));
   assign plru_idx     = write_commit ? victim_p1 : hit_idx;

   tlbplru #(
      .ENTRIES (TLB_ENTRIES),
      .IDX_W   (IDX_W)
   ) u_plru (
      .clk          (clk),
      .reset        (reset),
      .access_valid (plru_acc),
      .access_idx   (plru_idx),
      .victim       (plru_victim)
   );

   always_comb begin
      state_d   = state_q;
      FillReady = 1'b0;
      Busy      = 1'b0;
      WriteEn   = '0;
      accept    = 1'b0;
      case (state_q)
         FILL_IDLE: begin
            FillReady = !SFenceValid;
            accept    = FillValid && !SFenceValid;
            if (accept) state_d = FILL_WRITE;
         end
         FILL_WRITE: begin
            Busy = 1'b1;
            // A flush or reset in this cycle cancels the write entirely.
            if (!SFenceValid && !reset)
               WriteEn = {{(TLB_ENTRIES-1){1'b0}}, 1'b1} << victim_p1;
            state_d = FILL_IDLE;
         end
         default: state_d = FILL_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= FILL_IDLE;
      else       state_q <= state_d;
   end

   // Accept stage: capture PTE and victim choice.
   always_ff @(posedge clk) begin
      if (reset) begin
         pte_p1    <= '0;
         victim_p1 <= '0;
      end else if (accept) begin
         pte_p1    <= FillPTE;
         victim_p1 <= next_victim;
      end
   end

   // Write stage: set the victim's valid bit unless a flush wins.
   always_ff @(posedge clk) begin
      if (reset)
         valid_q <= '0;
      else if (SFenceValid)
         valid_q <= SFenceAll ? '0 : (valid_q & GlobalVec);
      else if (state_q == FILL_WRITE)
         valid_q[victim_p1] <= 1'b1;
   end

   assign WritePTE = pte_p1;
   assign Valid    = valid_q;

endmodule

// File: tb/tb_tlb_fill_ctrl.sv
module tb_tlb_fill_ctrl;
   import config_pkg::*;

   localparam int N = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            FillValid;
   logic            FillReady;
   logic [XLEN-1:0] FillPTE;
   logic            TLBAccess;
   logic [N-1:0]    HitVec;
   logic [N-1:0]    GlobalVec;
   logic            SFenceValid;
   logic            SFenceAll;
   logic [N-1:0]    WriteEn;
   logic [XLEN-1:0] WritePTE;
   logic [N-1:0]    Valid;
   logic            Busy;

   tlb_fill_ctrl #(.TLB_ENTRIES(N)) dut (
      .clk         (clk),
      .reset       (reset),
      .FillValid   (FillValid),
      .FillReady   (FillReady),
      .FillPTE     (FillPTE),
      .TLBAccess   (TLBAccess),
      .HitVec      (HitVec),
      .GlobalVec   (GlobalVec),
      .SFenceValid (SFenceValid),
      .SFenceAll   (SFenceAll),
      .WriteEn     (WriteEn),
      .WritePTE    (WritePTE),
      .Valid       (Valid),
      .Busy        (Busy)
   );

   always #5 clk = ~clk;

   // One row = one clock cycle: inputs plus the outputs expected before the
   // edge. push_we != 0 means this row's fill must be written next cycle.
   typedef struct {
      logic            rst;
      logic            fv;
      logic [XLEN-1:0] pte;
      logic            acc;
      logic [N-1:0]    hit;
      logic            sfv;
      logic            sfall;
      logic [N-1:0]    glob;
      logic            ready;
      logic            busy;
      logic [N-1:0]    we;
      logic [N-1:0]    valid;
      logic [XLEN-1:0] wpte;
      logic [N-1:0]    push_we;
   } vec_t;

   typedef struct {
      logic [N-1:0]    we;
      logic [XLEN-1:0] pte;
   } sb_t;

   vec_t tbl[$];
   sb_t  sb[$];
   logic [XLEN-1:0] cur_pte;
   int   n_chk;
   int   n_fail;
   int   row;

   task automatic add(input logic r, input logic fv, input logic [XLEN-1:0] pte,
                      input logic acc, input logic [N-1:0] hit, input logic sfv,
                      input logic sfall, input logic [N-1:0] glob,
                      input logic ready, input logic busy, input logic [N-1:0] we,
                      input logic [N-1:0] valid, input logic [N-1:0] push_we);
      vec_t v;
      v.rst = r; v.fv = fv; v.pte = pte; v.acc = acc; v.hit = hit;
      v.sfv = sfv; v.sfall = sfall; v.glob = glob;
      v.ready = ready; v.busy = busy; v.we = we; v.valid = valid;
      v.wpte = cur_pte; v.push_we = push_we;
      tbl.push_back(v);
      if (r) cur_pte = '0;
      else if (fv && ready) cur_pte = pte;
   endtask

   task automatic fill(input logic [XLEN-1:0] pte, input logic [N-1:0] valid,
                       input logic [N-1:0] push_we);
      add(0, 1, pte, 0, '0, 0, 0, '0, 1, 0, '0, valid, push_we);
   endtask

   task automatic wr(input logic [N-1:0] we, input logic [N-1:0] valid);
      add(0, 0, '0, 0, '0, 0, 0, '0, 0, 1, we, valid, '0);
   endtask

   task automatic idle(input logic [N-1:0] valid);
      add(0, 0, '0, 0, '0, 0, 0, '0, 1, 0, '0, valid, '0);
   endtask

   task automatic four_fills();
      for (int k = 0; k < 4; k++) begin
         fill(XLEN'((k + 1) * 17), N'((1 << k) - 1), N'(1 << k));
         wr(N'(1 << k), N'((1 << k) - 1));
      end
   endtask

   task automatic chk(input string name, input logic [XLEN-1:0] act,
                      input logic [XLEN-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
      end
   endtask

   initial begin
      sb_t s;
      n_chk = 0; n_fail = 0; row = -1; cur_pte = '0;

      // Scenario A: four fills, PLRU victims, hit during WRITE ignored.
      four_fills();
      idle(4'b1111);
      fill(64'h55, 4'b1111, 4'b0001);
      add(0, 0, '0, 1, 4'b0100, 0, 0, '0, 0, 1, 4'b0001, 4'b1111, '0);
      fill(64'h66, 4'b1111, 4'b0100);
      wr(4'b0100, 4'b1111);
      // Scenario B: reset, four fills, hit on entry 0 steers the next fill.
      add(1, 0, '0, 0, '0, 0, 0, '0, 1, 0, '0, 4'b1111, '0);
      four_fills();
      add(0, 0, '0, 1, 4'b0001, 0, 0, '0, 1, 0, '0, 4'b1111, '0);
      fill(64'h77, 4'b1111, 4'b0100);
      wr(4'b0100, 4'b1111);
      // Scenario C: non-global flush with a concurrent fill request.
      add(0, 1, 64'hEE, 0, '0, 1, 0, 4'b0101, 0, 0, '0, 4'b1111, '0);
      idle(4'b0101);
      fill(64'h88, 4'b0101, 4'b0010);
      wr(4'b0010, 4'b0101);
      idle(4'b0111);
      // Scenario D: flush-all during WRITE drops the fill.
      fill(64'h99, 4'b0111, '0);
      add(0, 0, '0, 0, '0, 1, 1, '0, 0, 1, '0, 4'b0111, '0);
      idle(4'b0000);
      // Scenario E: reset during WRITE.
      fill(64'hAA, 4'b0000, '0);
      add(1, 0, '0, 0, '0, 0, 0, '0, 0, 1, '0, 4'b0000, '0);
      idle(4'b0000);

      reset = 1'b1; FillValid = 0; FillPTE = '0; TLBAccess = 0; HitVec = '0;
      GlobalVec = '0; SFenceValid = 0; SFenceAll = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("reset_ready", XLEN'(FillReady), 1);
      chk("reset_busy", XLEN'(Busy), 0);
      chk("reset_we", XLEN'(WriteEn), 0);
      chk("reset_wpte", WritePTE, 0);
      chk("reset_valid", XLEN'(Valid), 0);

      for (int i = 0; i < tbl.size(); i++) begin
         if (i > 0) @(negedge clk);
         row         = i;
         reset       = tbl[i].rst;
         FillValid   = tbl[i].fv;
         FillPTE     = tbl[i].pte;
         TLBAccess   = tbl[i].acc;
         HitVec      = tbl[i].hit;
         SFenceValid = tbl[i].sfv;
         SFenceAll   = tbl[i].sfall;
         GlobalVec   = tbl[i].glob;
         #1;
         chk("ready", XLEN'(FillReady), XLEN'(tbl[i].ready));
         chk("busy", XLEN'(Busy), XLEN'(tbl[i].busy));
         chk("we", XLEN'(WriteEn), XLEN'(tbl[i].we));
         chk("valid", XLEN'(Valid), XLEN'(tbl[i].valid));
         chk("wpte", WritePTE, tbl[i].wpte);
         if (WriteEn != '0) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected_write", XLEN'(WriteEn), 0);
            end else begin
               s = sb.pop_front();
               chk("sb_we", XLEN'(WriteEn), XLEN'(s.we));
               chk("sb_pte", WritePTE, s.pte);
            end
         end
         if (tbl[i].push_we != '0) begin
            s.we  = tbl[i].push_we;
            s.pte = tbl[i].pte;
            sb.push_back(s);
         end
      end
      @(negedge clk);
      chk("sb_drained", XLEN'(sb.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
